// File: rtl/dlc_omi_prbs7_bist_ctl_pkg.sv
// ============================================================================
// dlc_omi_prbs7_bist_ctl_pkg : shared state encodings and defaults - Rev 1.0
// ============================================================================
`default_nettype none

package dlc_omi_prbs7_bist_ctl_pkg;

  localparam int LANES_DEF    = 8;
  localparam int SETTLE_W_DEF = 8;
  localparam int WINDOW_W_DEF = 16;

  // Checker input register plus error flop
  localparam int DRAIN_CYCLES = 2;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic logic is_busy_state(input state_t s);
    return (s == ST_SETTLE) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dlc_omi_prbs7_bist_ctl_if.sv
// ============================================================================
// dlc_omi_prbs7_bist_ctl_if : control/result bus of the PRBS7 BIST sequencer - Rev 1.0
// ============================================================================
`default_nettype none

interface dlc_omi_prbs7_bist_ctl_if #(
  parameter int LANES    = 8,
  parameter int SETTLE_W = 8,
  parameter int WINDOW_W = 16
);

  logic                bist_start;
  logic                bist_abort;
  logic [LANES-1:0]    lane_mask;
  logic [SETTLE_W-1:0] settle_cycles;
  logic [WINDOW_W-1:0] window_cycles;
  logic [LANES-1:0]    lane_err;
  logic [LANES-1:0]    rx_bist_reset;
  logic                bist_busy;
  logic                bist_done;
  logic                bist_pass;
  logic [LANES-1:0]    bist_fail_lanes;

  modport master (
    output bist_start, bist_abort, lane_mask, settle_cycles, window_cycles, lane_err,
    input  rx_bist_reset, bist_busy, bist_done, bist_pass, bist_fail_lanes
  );

  modport slave (
    input  bist_start, bist_abort, lane_mask, settle_cycles, window_cycles, lane_err,
    output rx_bist_reset, bist_busy, bist_done, bist_pass, bist_fail_lanes
  );

endinterface

`default_nettype wire

// File: rtl/dlc_omi_bist_cnt.sv
// ============================================================================
// dlc_omi_bist_cnt : loadable down-counter, zero load clamps to one - Rev 1.0
// ============================================================================
`default_nettype none

module dlc_omi_bist_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             is_one
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      if (load)
        count <= (load_val == '0) ? ONE : load_val;
      else if (dec && (count != '0))
        count <= count - ONE;
    end
  end

  assign is_one = (count == ONE);

endmodule

`default_nettype wire

// File: rtl/dlc_omi_prbs7_bist_ctl.sv
// ============================================================================
// dlc_omi_prbs7_bist_ctl : PRBS7 lane-checker BIST sequencer - Rev 1.0
// ============================================================================
`default_nettype none

module dlc_omi_prbs7_bist_ctl
  import dlc_omi_prbs7_bist_ctl_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF,
  parameter int WINDOW_W = WINDOW_W_DEF
) (
  input  logic                    phy_dl_clock,
  input  logic                    omi_reset_n,
  input  logic                    omi_enable,
  dlc_omi_prbs7_bist_ctl_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [LANES-1:0] mask_q;
  logic [LANES-1:0] mask_nxt;
  logic [LANES-1:0] fail_q;
  logic [LANES-1:0] fail_nxt;
  logic             run_first;
  logic [1:0]       drain_cnt;
  logic             settle_one;
  logic             window_one;
  logic             start_ok;
  logic             sample_err;

  logic [LANES-1:0] rx_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  assign start_ok   = bus.bist_start && !bus.bist_abort &&
                      ((state == ST_IDLE) || (state == ST_DONE));
  // First RUN cycle is the checker's clear cycle, so its flag is not trusted yet
  assign sample_err = ((state == ST_RUN) && !run_first) || (state == ST_DRAIN);

  dlc_omi_bist_cnt #(.WIDTH(SETTLE_W)) u_settle_cnt (
    .clk      (phy_dl_clock),
    .rst_n    (omi_reset_n),
    .en       (omi_enable),
    .load     (start_ok),
    .dec      (state == ST_SETTLE),
    .load_val (bus.settle_cycles),
    .is_one   (settle_one)
  );

  dlc_omi_bist_cnt #(.WIDTH(WINDOW_W)) u_window_cnt (
    .clk      (phy_dl_clock),
    .rst_n    (omi_reset_n),
    .en       (omi_enable),
    .load     ((state == ST_SETTLE) && settle_one),
    .dec      (state == ST_RUN),
    .load_val (bus.window_cycles),
    .is_one   (window_one)
  );

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    fail_nxt  = fail_q;
    if (sample_err)
      fail_nxt = fail_q | (bus.lane_err & mask_q);
    if (bus.bist_abort) begin
      state_nxt = ST_IDLE;
      fail_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.bist_start) begin
            state_nxt = ST_SETTLE;
            mask_nxt  = bus.lane_mask;
            fail_nxt  = '0;
          end
        end
        ST_SETTLE: if (settle_one) state_nxt = ST_RUN;
        ST_RUN:    if (window_one) state_nxt = ST_DRAIN;
        ST_DRAIN:  if (drain_cnt == 2'd1) state_nxt = ST_DONE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge phy_dl_clock) begin
    if (!omi_reset_n) begin
      state     <= ST_IDLE;
      mask_q    <= '0;
      fail_q    <= '0;
      run_first <= 1'b0;
      drain_cnt <= 2'd0;
      rx_q      <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else if (omi_enable) begin
      state     <= state_nxt;
      mask_q    <= mask_nxt;
      fail_q    <= fail_nxt;
      run_first <= (state != ST_RUN) && (state_nxt == ST_RUN);
      if ((state == ST_RUN) && window_one)
        drain_cnt <= 2'(DRAIN_CYCLES);
      else if ((state == ST_DRAIN) && (drain_cnt != 2'd0))
        drain_cnt <= drain_cnt - 2'd1;
      rx_q      <= ((state_nxt == ST_RUN) || (state_nxt == ST_DRAIN)) ? ~mask_nxt : '1;
      busy_q    <= is_busy_state(state_nxt);
      done_q    <= (state_nxt == ST_DONE);
      pass_q    <= (state_nxt == ST_DONE) && (fail_nxt == '0);
    end
  end

  assign bus.rx_bist_reset   = rx_q;
  assign bus.bist_busy       = busy_q;
  assign bus.bist_done       = done_q;
  assign bus.bist_pass       = pass_q;
  assign bus.bist_fail_lanes = fail_q;

endmodule

`default_nettype wire
